// File: rtl/lcd_pkg.sv
// lcd_pkg: shared status codes, FSM states and write-entry layout for the LCD VRAM arbiter
package lcd_pkg;
  localparam int ROW_W = 7;
  localparam int COL_W = 2;
  localparam int DATA_W = 32;
  localparam int ENTRY_W = ROW_W + COL_W + DATA_W;
  localparam logic [1:0] LCD_INIT = 2'd0;
  localparam logic [1:0] LCD_READY = 2'd1;
  localparam logic [1:0] LCD_BUSY = 2'd2;
  localparam logic [1:0] LCD_FINISH = 2'd3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REFRESH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [DATA_W-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/lcd_wr_fifo.sv
// lcd_wr_fifo: per-requester synchronous write FIFO; pointers carry a wrap bit to tell full from empty
module lcd_wr_fifo
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t din,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  wr_entry_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/lcd_vram_arbiter.sv
// lcd_vram_arbiter: round-robin sharing of the lcd_top VRAM write port between two requesters,
// plus serialised refresh (drain, pulse, BUSY/done handshake with timeout).
module lcd_vram_arbiter
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        I_status,
  input  logic              I_a_valid,
  output logic              O_a_ready,
  input  logic [ROW_W-1:0]  I_a_row,
  input  logic [COL_W-1:0]  I_a_col,
  input  logic [DATA_W-1:0] I_a_data,
  input  logic              I_b_valid,
  output logic              O_b_ready,
  input  logic [ROW_W-1:0]  I_b_row,
  input  logic [COL_W-1:0]  I_b_col,
  input  logic [DATA_W-1:0] I_b_data,
  input  logic              I_refresh_req,
  output logic              O_vram_we,
  output logic [ROW_W-1:0]  O_row,
  output logic [COL_W-1:0]  O_col,
  output logic [DATA_W-1:0] O_data,
  output logic              O_refresh,
  output logic              O_busy,
  output logic              O_err_timeout
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state, state_nx;
  wr_entry_t a_dout, b_dout;
  logic a_full, a_empty, b_full, b_empty;
  logic grant, sel_b, last_b, pending, status_ready, timed_out;
  logic [CW-1:0] cnt;
  assign status_ready = I_status == LCD_READY;
  assign timed_out = cnt == CW'(TIMEOUT - 1);
  lcd_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rstn(rstn),
    .push(I_a_valid && O_a_ready), .pop(grant && !sel_b),
    .din({I_a_row, I_a_col, I_a_data}), .dout(a_dout),
    .full(a_full), .empty(a_empty)
  );
  lcd_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rstn(rstn),
    .push(I_b_valid && O_b_ready), .pop(grant && sel_b),
    .din({I_b_row, I_b_col, I_b_data}), .dout(b_dout),
    .full(b_full), .empty(b_empty)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (I_refresh_req || pending) state_nx = ST_DRAIN;
      ST_DRAIN:     if (a_empty && b_empty && status_ready) state_nx = ST_REFRESH;
      ST_REFRESH:   state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY: state_nx = I_status == LCD_BUSY ? ST_WAIT_DONE : timed_out ? ST_IDLE : ST_WAIT_BUSY;
      ST_WAIT_DONE: if (status_ready || I_status == LCD_FINISH)
                      state_nx = (pending || I_refresh_req) ? ST_DRAIN : ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end
  always_comb begin
    O_refresh = state == ST_REFRESH;
    O_busy = state != ST_IDLE || pending;
    O_a_ready = !a_full && state != ST_DRAIN;
    O_b_ready = !b_full && state != ST_DRAIN;
    grant = (state == ST_IDLE || state == ST_DRAIN) && status_ready && !(a_empty && b_empty);
    sel_b = !b_empty && (a_empty || !last_b);
  end
  // last_b resets high so that A wins the first contested grant
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      O_vram_we <= 1'b0;
      {O_row, O_col, O_data} <= '0;
      last_b <= 1'b1;
      cnt <= '0;
      pending <= 1'b0;
      O_err_timeout <= 1'b0;
    end else begin
      O_vram_we <= grant;
      if (grant) begin
        last_b <= sel_b;
        {O_row, O_col, O_data} <= sel_b ? b_dout : a_dout;
      end
      cnt <= state != ST_WAIT_BUSY ? '0 : &cnt ? cnt : cnt + 1'b1;
      if (state == ST_WAIT_BUSY && state_nx == ST_IDLE) O_err_timeout <= 1'b1;
      if (state_nx == ST_DRAIN) pending <= 1'b0;
      else if (I_refresh_req && state inside {ST_REFRESH, ST_WAIT_BUSY, ST_WAIT_DONE}) pending <= 1'b1;
    end
endmodule

// File: tb/tb_lcd_vram_arbiter.sv
// tb_lcd_vram_arbiter: randomized scoreboard bench with a queue-level round-robin reference model
module tb_lcd_vram_arbiter;
  import lcd_pkg::*;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  logic clk = 1'b0, rstn = 1'b0;
  logic [1:0] I_status;
  logic I_a_valid, O_a_ready, I_b_valid, O_b_ready, I_refresh_req;
  logic [6:0] I_a_row, I_b_row, O_row;
  logic [1:0] I_a_col, I_b_col, O_col;
  logic [31:0] I_a_data, I_b_data, O_data;
  logic O_vram_we, O_refresh, O_busy, O_err_timeout;
  lcd_vram_arbiter #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .I_status(I_status),
    .I_a_valid(I_a_valid), .O_a_ready(O_a_ready), .I_a_row(I_a_row), .I_a_col(I_a_col), .I_a_data(I_a_data),
    .I_b_valid(I_b_valid), .O_b_ready(O_b_ready), .I_b_row(I_b_row), .I_b_col(I_b_col), .I_b_data(I_b_data),
    .I_refresh_req(I_refresh_req), .O_vram_we(O_vram_we), .O_row(O_row), .O_col(O_col), .O_data(O_data),
    .O_refresh(O_refresh), .O_busy(O_busy), .O_err_timeout(O_err_timeout)
  );
  always #5 clk = ~clk;
  int cyc = 0, passed = 0, total = 0;
  int we_cnt = 0, first_we = -1, last_we = -1, ref_cnt = 0;
  logic [40:0] sb[$], ma[$], mb[$];
  bit m_last_b = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", n, got, exp);
  endtask
  always @(negedge clk)
    if (rstn) begin
      if (O_vram_we) begin
        if (sb.size() == 0) chk("write_unexpected", {O_row, O_col, O_data}, 64'hx);
        else chk("write_data", {O_row, O_col, O_data}, sb.pop_front());
        we_cnt++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (O_refresh) ref_cnt++;
    end
  // expected write order: alternate while both queues hold data, otherwise drain whichever remains
  task automatic release_model();
    while (ma.size() + mb.size() > 0) begin
      bit pb = (ma.size() > 0 && mb.size() > 0) ? !m_last_b : mb.size() > 0;
      sb.push_back(pb ? mb.pop_front() : ma.pop_front());
      m_last_b = pb;
    end
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    I_a_valid = 0; I_b_valid = 0; I_refresh_req = 0; I_status = LCD_INIT;
    I_a_row = 0; I_a_col = 0; I_a_data = 0; I_b_row = 0; I_b_col = 0; I_b_data = 0;
    sb.delete(); ma.delete(); mb.delete(); m_last_b = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  function automatic logic [40:0] rnd();
    return 41'({$urandom(), $urandom()});
  endfunction
  task automatic push(input bit b, input logic [40:0] e);
    int n = 0;
    @(negedge clk);
    if (b) begin I_b_valid = 1; {I_b_row, I_b_col, I_b_data} = e; end
    else begin I_a_valid = 1; {I_a_row, I_a_col, I_a_data} = e; end
    while (!(b ? O_b_ready : O_a_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      chk("push_timeout", 0, 1);
      I_a_valid = 0; I_b_valid = 0;
    end else begin
      if (b) mb.push_back(e); else ma.push_back(e);
      @(posedge clk); #1;
      I_a_valid = 0; I_b_valid = 0;
    end
  endtask
  task automatic pulse_refresh();
    @(negedge clk) I_refresh_req = 1;
    @(negedge clk) I_refresh_req = 0;
  endtask
  task automatic wait_refresh(input string n);
    int k = 0;
    while (!O_refresh && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk(n, 0, 1);
  endtask
  initial begin
    #300000 $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    int w0, rc;
    logic [40:0] e1, e2;
    do_reset();
    chk("rst_we", O_vram_we, 0);
    chk("rst_busy", O_busy, 0);
    chk("rst_err", O_err_timeout, 0);
    chk("rst_ready", {O_a_ready, O_b_ready}, 2'b11);
    // first-write latency and back-to-back strobes
    I_status = LCD_READY;
    e1 = {7'd32, 2'd1, 32'hffffffff};
    e2 = {7'd32, 2'd2, 32'hf0f0f0f0};
    @(negedge clk);
    I_a_valid = 1; {I_a_row, I_a_col, I_a_data} = e1; sb.push_back(e1);
    @(posedge clk); #1;
    {I_a_row, I_a_col, I_a_data} = e2; sb.push_back(e2);
    @(negedge clk) chk("t1_no_we_n1", O_vram_we, 0);
    @(posedge clk); #1 I_a_valid = 0;
    @(negedge clk) chk("t1_we_n2", O_vram_we, 1);
    @(negedge clk) chk("t1_we_n3", O_vram_we, 1);
    @(negedge clk) chk("t1_we_off", O_vram_we, 0);
    chk("t1_hold", {O_row, O_col, O_data}, e2);
    // contested round robin
    do_reset();
    for (int i = 0; i < 3; i++) begin push(0, rnd()); push(1, rnd()); end
    w0 = we_cnt;
    repeat (4) @(negedge clk);
    chk("t2_stall_init", we_cnt, w0);
    release_model();
    first_we = -1;
    I_status = LCD_READY;
    repeat (10) @(negedge clk);
    chk("t2_count", we_cnt - w0, 6);
    chk("t2_b2b", last_we - first_we, 5);
    for (int r = 0; r < 3; r++) begin
      int na = $urandom_range(0, DEPTH), nb = $urandom_range(0, DEPTH);
      I_status = LCD_INIT;
      for (int i = 0; i < DEPTH; i++) begin
        if (i < na) push(0, rnd());
        if (i < nb) push(1, rnd());
      end
      w0 = we_cnt;
      release_model();
      @(negedge clk) I_status = LCD_READY;
      repeat (12) @(negedge clk);
      chk("t2_rand_count", we_cnt - w0, na + nb);
    end
    // stall under INIT and full FIFO
    I_status = LCD_INIT;
    push(0, rnd()); push(0, rnd());
    w0 = we_cnt;
    repeat (5) @(negedge clk);
    chk("t3_stall", we_cnt, w0);
    release_model();
    I_status = LCD_READY;
    repeat (6) @(negedge clk);
    chk("t3_count", we_cnt - w0, 2);
    I_status = LCD_INIT;
    for (int i = 0; i < DEPTH; i++) push(0, rnd());
    @(negedge clk) chk("t3_full", O_a_ready, 0);
    chk("t3_b_ready", O_b_ready, 1);
    w0 = we_cnt;
    release_model();
    I_status = LCD_READY;
    repeat (8) @(negedge clk);
    chk("t3_full_count", we_cnt - w0, DEPTH);
    chk("t3_ready_again", O_a_ready, 1);
    // refresh: drain, pulse, BUSY handshake
    I_status = LCD_INIT;
    push(0, rnd()); push(0, rnd());
    w0 = we_cnt; rc = ref_cnt;
    pulse_refresh();
    chk("t4_drain_ready", O_a_ready, 0);
    chk("t4_drain_busy", O_busy, 1);
    release_model();
    I_status = LCD_READY;
    wait_refresh("t4_refresh_seen");
    chk("t4_refresh_gap", cyc - last_we, 1);
    chk("t4_writes", we_cnt - w0, 2);
    I_status = LCD_BUSY;
    @(negedge clk) chk("t4_pulse_width", O_refresh, 0);
    repeat (9) @(negedge clk);
    I_status = LCD_READY;
    #1 chk("t4_busy_hold", O_busy, 1);
    @(negedge clk) chk("t4_busy_drop", O_busy, 0);
    chk("t4_one_pulse", ref_cnt - rc, 1);
    // timeout
    do_reset();
    I_status = LCD_READY;
    pulse_refresh();
    wait_refresh("t5_refresh_seen");
    repeat (TO) @(negedge clk);
    chk("t5_err_early", O_err_timeout, 0);
    @(negedge clk) chk("t5_err", O_err_timeout, 1);
    chk("t5_idle", O_busy, 0);
    w0 = we_cnt;
    for (int i = 0; i < 2; i++) begin push(0, rnd()); release_model(); end
    repeat (6) @(negedge clk);
    chk("t5_resume", we_cnt - w0, 2);
    chk("t5_sticky", O_err_timeout, 1);
    // coalesced requests during WAIT_DONE
    do_reset();
    I_status = LCD_READY;
    pulse_refresh();
    wait_refresh("t6_refresh_seen");
    I_status = LCD_BUSY;
    repeat (3) @(negedge clk);
    rc = ref_cnt;
    pulse_refresh();
    @(negedge clk);
    pulse_refresh();
    chk("t6_busy_pending", O_busy, 1);
    I_status = LCD_READY;
    repeat (40) @(negedge clk);
    chk("t6_one_extra", ref_cnt - rc, 1);
    chk("t6_idle", O_busy, 0);
    // async reset mid WAIT_DONE
    do_reset();
    I_status = LCD_READY;
    push(1, rnd()); release_model();
    repeat (4) @(negedge clk);
    pulse_refresh();
    wait_refresh("t7_refresh_seen");
    I_status = LCD_BUSY;
    push(0, rnd()); push(0, rnd());
    chk("t7_busy", O_busy, 1);
    @(negedge clk); #2 rstn = 1'b0;
    #1;
    chk("t7_rst_outs", {O_vram_we, O_refresh, O_busy, O_err_timeout}, 4'b0);
    chk("t7_rst_bus", {O_row, O_col, O_data}, 41'b0);
    w0 = we_cnt; rc = ref_cnt;
    do_reset();
    I_status = LCD_READY;
    repeat (6) @(negedge clk);
    chk("t7_fifo_empty", we_cnt - w0, 0);
    chk("t7_no_refresh", ref_cnt - rc, 0);
    chk("t7_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lcd_vram_arbiter.md
Name: lcd_vram_arbiter

Overview:
- Shares the single VRAM write port and the refresh trigger of lcd_top between two requesters, A (CPU store path) and B (debug/console renderer).
- Each requester gets a small write FIFO.
- The arbiter grants round-robin, issuing at most one write per cycle and only while lcd_top reports READY.
- It serialises refresh requests: drain both FIFOs, pulse refresh, then track the BUSY-to-done handshake with a timeout.

Parameters:
- FIFO_DEPTH, 4, entries per requester FIFO; power of 2, ≥2.
- TIMEOUT, 1024, maximum cycles to wait in WAIT_BUSY for status to become BUSY after a refresh pulse.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- I_status  in  2  lcd_top status: 0 INIT, 1 READY, 2 BUSY, 3 FINISH
- I_a_valid  in  1  requester A write valid
- O_a_ready  out  1  requester A FIFO can accept
- I_a_row  in  7  requester A row
- I_a_col  in  2  requester A column word
- I_a_data  in  32  requester A pixel data
- I_b_valid, O_b_ready, I_b_row, I_b_col, I_b_data  same as A, for requester B
- I_refresh_req  in  1  refresh request; pulse or level, sampled each cycle
- O_vram_we  out  1  write strobe to lcd_top
- O_row  out  7  write row
- O_col  out  2  write column
- O_data  out  32  write data
- O_refresh  out  1  one-cycle refresh pulse to lcd_top
- O_busy  out  1  refresh pending or in progress
- O_err_timeout  out  1  sticky: BUSY not observed within TIMEOUT

Behaviour:
- Reset (async, rstn=0):
  - FIFOs emptied; FSM to IDLE; round-robin pointer favours A.
  - O_vram_we, O_refresh, O_busy, O_err_timeout, O_row, O_col, O_data all 0.
  - Same applies when reset hits mid-operation; no partial write or refresh is replayed.
- FIFO handshake:
  - Push on valid&&ready.
  - ready = !full && FSM not in DRAIN.
  - Data is held while ready=0.
- Grant:
  - Evaluated in IDLE and DRAIN, when I_status==READY and at least one FIFO is non-empty.
  - If both are non-empty, grant the FIFO not granted last; the pointer updates only on a grant.
  - The granted FIFO pops that cycle.
  - Next cycle: O_vram_we=1 with the popped row/col/data.
  - Back-to-back writes every cycle are allowed.
- Latency: handshake at cycle N → entry visible N+1 → O_vram_we at N+2 (minimum).
- When O_vram_we=0, O_row/O_col/O_data hold their last values.
- No grants while I_status is INIT, BUSY or FINISH, or while the FSM is in REFRESH, WAIT_BUSY or WAIT_DONE.
- FSM states:
  - IDLE: I_refresh_req=1 → DRAIN.
  - DRAIN: both FIFOs empty and I_status==READY → REFRESH. A request arriving here merges with the current one.
  - REFRESH: one cycle; O_refresh=1 → WAIT_BUSY; timeout counter cleared.
  - WAIT_BUSY: I_status==BUSY → WAIT_DONE. If the counter reaches TIMEOUT-1, set O_err_timeout → IDLE.
  - WAIT_DONE: I_status is READY or FINISH → IDLE, or → DRAIN if a refresh request arrived during REFRESH, WAIT_BUSY or WAIT_DONE (latched in a pending bit, coalesced to one).
- O_busy = (state != IDLE) || pending.
- Pushes are accepted during REFRESH, WAIT_BUSY and WAIT_DONE (buffered); they are blocked only in DRAIN.
- Simultaneous refresh request and a grant in IDLE: the grant proceeds; the FSM enters DRAIN the next cycle.
- O_err_timeout is cleared only by reset.
- Timeout counter width is $clog2(TIMEOUT)+1; it saturates and does not wrap.
- FIFO pointers are DEPTH_LOG2+1 bits wide with wrap bit:
  - full = pointers equal except MSB;
  - empty = pointers fully equal.

Decomposition:
- Package lcd_pkg:
  - status constants LCD_INIT=0, LCD_READY=1, LCD_BUSY=2, LCD_FINISH=3;
  - FSM state encoding;
  - widths ROW_W=7, COL_W=2, DATA_W=32.
- One sub-module, lcd_wr_fifo:
  - synchronous FIFO, 41-bit entry {row,col,data}, parameter FIFO_DEPTH;
  - ports push/pop/full/empty;
  - instantiated twice.

Test Plan:
- A writes (32,1,ffffffff), then (32,2,f0f0f0f0), with status=READY → O_vram_we high on two consecutive cycles; first strobe 2 cycles after the first handshake; values in order.
- A and B both hold 3 entries, status READY → grant order A,B,A,B,A,B; six back-to-back strobes.
- Status=INIT while 2 entries are queued, then READY → no strobes during INIT; 2 strobes after READY; FIFO_DEPTH pushes fill the FIFO, and O_a_ready=0 at full.
- 2 entries queued, then refresh_req pulse → both writes issued; O_a_ready=0 during DRAIN; O_refresh pulses exactly 1 cycle after the FIFOs empty. Model status BUSY for 10 cycles then READY → O_busy drops the cycle after READY.
- Refresh with status never BUSY, TIMEOUT=16 → O_err_timeout=1 after 16 WAIT_BUSY cycles; FSM back to IDLE; writes resume.
- Two refresh_req pulses during WAIT_DONE, then rstn asserted mid-WAIT_DONE in a second run → first run: exactly one extra O_refresh pulse; second run: all outputs 0 immediately and FIFOs empty.
